// File: rtl/mmio_console_tx.sv
// Memory-mapped console transmitter: CPU stores to TXDATA feed a byte FIFO
// that an 8N1 serializer drains onto the tx line and a byte-strobe log port.
module mmio_console_tx #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] BASE_ADDR    = 32'h0000FF00,
  parameter int                DEPTH        = 8,
  parameter int                CLKS_PER_BIT = 4
) (
  input  logic              InputClk,
  input  logic              rst,
  input  logic [DATA_W-1:0] AddressBus,
  input  logic [DATA_W-1:0] DataBusWr,
  input  logic [2:0]        ControlBus,
  output logic [DATA_W-1:0] DataBusRd,
  output logic              Hit,
  output logic              tx,
  output logic [7:0]        TxByte,
  output logic              TxStrobe,
  output logic [15:0]       DropCount
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int TIMER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- decode
  logic [DATA_W-1:0] offset;
  logic              in_win;
  logic [1:0]        word_sel;
  logic              wr_en;
  logic              rd_en;

  // Subtracting the base makes addresses below the window wrap to huge
  // values, so a single unsigned compare bounds both sides.
  assign offset   = {AddressBus[DATA_W-1:2], 2'b00} - BASE_ADDR;
  assign in_win   = (offset < DATA_W'(12));
  assign word_sel = offset[3:2];
  assign wr_en    = ControlBus[2];
  assign rd_en    = ControlBus[1] & ~ControlBus[2];
  assign Hit      = in_win & (ControlBus[1] | ControlBus[2]);

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      drop_q, drop_d;
  logic             full, empty, busy;
  logic             push_req, push_ok, pop, drop, clr_ovf;

  state_t           state_q, state_d;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign busy     = (state_q != S_IDLE);

  assign push_req = in_win & wr_en & (word_sel == REG_TXDATA);
  assign clr_ovf  = in_win & wr_en & (word_sel == REG_CTRL) & DataBusWr[0];
  assign pop      = (state_q == S_IDLE) & ~empty;
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    drop_d   = drop_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define
  // which entries are valid, so the array maps onto plain RAM.
  always_ff @(posedge InputClk) begin
    if (push_ok) mem[wr_ptr_q] <= DataBusWr[7:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge InputClk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  // ---------------------------------------------------------------- read mux
  logic [DATA_W-1:0] status;

  assign status    = {{(DATA_W-16){1'b0}}, 8'(count_q), 4'b0000, ovf_q, full, empty, busy};
  assign DataBusRd = (in_win && rd_en && (word_sel == REG_STATUS)) ? status : '0;
  assign DropCount = drop_q;

  // ---------------------------------------------------------------- serializer
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [2:0]         bit_q, bit_d;
  logic               tx_q, tx_d;
  logic [7:0]         txbyte_q, txbyte_d;
  logic               strobe_q, strobe_d;
  logic               last_clk;

  assign last_clk = (timer_q == TIMER_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    txbyte_d = txbyte_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          state_d  = S_START;
          txbyte_d = mem[rd_ptr_q];
          tx_d     = 1'b0;
          timer_d  = '0;
        end
      end
      S_START: begin
        if (last_clk) begin
          state_d = S_DATA;
          timer_d = '0;
          bit_d   = 3'd0;
          tx_d    = txbyte_q[0];
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DATA: begin
        if (last_clk) begin
          timer_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = txbyte_q[bit_d];
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_STOP: begin
        if (last_clk) state_d = S_IDLE;
        else          timer_d = timer_q + TIMER_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // Registered strobe must already be high during the final stop clock.
    strobe_d = (state_d == S_STOP) && (timer_d == TIMER_W'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge InputClk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      txbyte_q <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      txbyte_q <= txbyte_d;
      strobe_q <= strobe_d;
    end
  end

  assign tx       = tx_q;
  assign TxByte   = txbyte_q;
  assign TxStrobe = strobe_q;

  logic unused_bits;
  assign unused_bits = ^{AddressBus[1:0], DataBusWr[DATA_W-1:8], ControlBus[0],
                         offset[DATA_W-1:4], offset[1:0]};

endmodule

// File: tb/tb_mmio_console_tx.sv
// Scoreboard bench for mmio_console_tx: stimulus queues expected bytes, line
// and strobe monitors pop and compare as frames and strobes appear.
module tb_mmio_console_tx;

  localparam logic [31:0] BASE = 32'h0000FF00;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  ctrl;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
  logic [7:0]  tx_byte;
  logic        tx_strobe;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  line_q[$];
  logic [7:0]  strobe_q[$];

  logic [31:0] rd_val;
  logic        rd_hit;
  logic [7:0]  lm_byte;
  logic        lm_abort;
  logic [31:0] lm_exp;
  logic [31:0] sm_exp;

  mmio_console_tx #(
    .DATA_W      (32),
    .BASE_ADDR   (BASE),
    .DEPTH       (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .InputClk  (clk),
    .rst       (rst),
    .AddressBus(addr),
    .DataBusWr (wdata),
    .ControlBus(ctrl),
    .DataBusRd (rdata),
    .Hit       (hit),
    .tx        (tx),
    .TxByte    (tx_byte),
    .TxStrobe  (tx_strobe),
    .DropCount (drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic expect_byte(input logic [7:0] b);
    line_q.push_back(b);
    strobe_q.push_back(b);
  endtask

  // All bus tasks start and end at posedge+1.
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, output logic h);
    addr  = a;
    wdata = d;
    ctrl  = 3'b100;
    @(negedge clk);
    h = hit;
    @(posedge clk);
    #1;
    ctrl = 3'b000;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a;
    ctrl = 3'b010;
    @(negedge clk);
    d = rdata;
    h = hit;
    @(posedge clk);
    #1;
    ctrl = 3'b000;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000; i++) begin
      if (line_q.size() == 0 && strobe_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_remaining", 32'(line_q.size() + strobe_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Line monitor: decodes each 8N1 frame at bit centres (4 clocks per bit).
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        lm_abort = 1'b0;
        lm_byte  = 8'h00;
        for (int k = 1; k <= 39 && !lm_abort; k++) begin
          @(negedge clk);
          if (rst !== 1'b1) begin
            lm_abort = 1'b1;
          end else begin
            if (k == 2) check("start_bit", {31'd0, tx}, 32'd0);
            if (k >= 6 && k <= 34 && ((k - 6) % 4) == 0) lm_byte[(k - 6) / 4] = tx;
            if (k == 38) check("stop_bit", {31'd0, tx}, 32'd1);
            if (k == 39) check("strobe_on_last_stop", {31'd0, tx_strobe}, 32'd1);
          end
        end
        if (!lm_abort) begin
          if (line_q.size() > 0) lm_exp = {24'd0, line_q.pop_front()};
          else                   lm_exp = 32'hDEADBEEF;
          check("line_byte", {24'd0, lm_byte}, lm_exp);
        end
      end
    end
  end

  // Strobe monitor: every strobe must carry the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx_strobe === 1'b1) begin
        if (strobe_q.size() > 0) sm_exp = {24'd0, strobe_q.pop_front()};
        else                     sm_exp = 32'hDEADBEEF;
        check("strobe_byte", {24'd0, tx_byte}, sm_exp);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic h;
    addr  = 32'd0;
    wdata = 32'd0;
    ctrl  = 3'b000;
    rst   = 1'b1;
    #1 rst = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_strobe", {31'd0, tx_strobe}, 32'd0);
    check("rst_txbyte", {24'd0, tx_byte}, 32'd0);
    check("rst_dropcount", {16'd0, drop_count}, 32'd0);
    bus_rd(BASE + 32'd4, rd_val, rd_hit);
    check("rst_status", rd_val, 32'h00000002);
    check("rst_status_hit", {31'd0, rd_hit}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single byte 0x41
    expect_byte(8'h41);
    bus_wr(BASE, 32'h41, h);
    check("txdata_hit", {31'd0, h}, 32'd1);
    wait_drain();
    check("single_dropcount", {16'd0, drop_count}, 32'd0);

    // Overflow: 10 back-to-back writes, last one dropped
    for (int i = 0; i < 10; i++) begin
      if (i < 9) expect_byte(8'(8'h30 + i));
      bus_wr(BASE, 32'h30 + 32'(i), h);
    end
    check("ovf_dropcount", {16'd0, drop_count}, 32'd1);

    // Status / clear
    bus_rd(BASE + 32'd4, rd_val, rd_hit);
    check("status_full", rd_val, 32'h0000080D);
    bus_wr(BASE + 32'd8, 32'h1, h);
    bus_rd(BASE + 32'd4, rd_val, rd_hit);
    check("status_ovf_cleared", rd_val, 32'h00000805);
    bus_rd(BASE, rd_val, rd_hit);
    check("read_txdata_zero", rd_val, 32'd0);
    bus_rd(BASE + 32'd8, rd_val, rd_hit);
    check("read_ctrl_zero", rd_val, 32'd0);

    // Decode: out-of-window accesses while the FIFO is full
    bus_rd(BASE + 32'd12, rd_val, rd_hit);
    check("oow_rd_data", rd_val, 32'd0);
    check("oow_rd_hit", {31'd0, rd_hit}, 32'd0);
    bus_rd(32'd0, rd_val, rd_hit);
    check("zero_rd_data", rd_val, 32'd0);
    check("zero_rd_hit", {31'd0, rd_hit}, 32'd0);
    bus_wr(BASE + 32'd12, 32'h77, h);
    check("oow_wr_hit", {31'd0, h}, 32'd0);
    bus_wr(32'd0, 32'h78, h);
    check("zero_wr_hit", {31'd0, h}, 32'd0);
    bus_wr(BASE + 32'd4, 32'hFFFFFFFF, h);
    bus_rd(BASE + 32'd4, rd_val, rd_hit);
    check("status_unchanged", rd_val, 32'h00000805);
    check("decode_dropcount", {16'd0, drop_count}, 32'd1);
    wait_drain();

    // Both enables at TXDATA: write only, read data zero
    expect_byte(8'h5A);
    addr  = BASE;
    wdata = 32'h5A;
    ctrl  = 3'b110;
    @(negedge clk);
    check("both_en_hit", {31'd0, hit}, 32'd1);
    check("both_en_rdata", rdata, 32'd0);
    @(posedge clk);
    #1;
    ctrl = 3'b000;
    bus_rd(BASE + 32'd4, rd_val, rd_hit);
    check("status_one_queued", rd_val, 32'h00000100);
    @(negedge clk);
    check("tx_falls_after_pop", {31'd0, tx}, 32'd0);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset mid-byte
    expect_byte(8'hA5);
    bus_wr(BASE, 32'hA5, h);
    expect_byte(8'h3C);
    bus_wr(BASE, 32'h3C, h);
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b0;
    line_q.delete();
    strobe_q.delete();
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_strobe", {31'd0, tx_strobe}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_rd(BASE + 32'd4, rd_val, rd_hit);
    check("midrst_status_empty", rd_val, 32'h00000002);
    check("midrst_dropcount", {16'd0, drop_count}, 32'd0);
    expect_byte(8'hC3);
    bus_wr(BASE, 32'hC3, h);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
